// File: rtl/wb_demux_pkg.sv
// Shared processor definitions for the write-back demultiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_demux_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int AW_DEF    = 5;
    localparam int ZREG_DEF  = 31;

    // One buffered write-back entry: write flag, destination register, value.
    typedef struct packed {
        logic                 we;
        logic [AW_DEF-1:0]    addr;
        logic [WIDTH_DEF-1:0] data;
    } entry_t;

    // True when the entry must not produce a register write enable.
    function automatic logic is_nowrite(input entry_t e);
        return (!e.we) || (e.addr == AW_DEF'(ZREG_DEF));
    endfunction

endpackage

// File: rtl/wb_demux_if.sv
// Write-back bus: producer handshake, register-file hold and decoded write port.
// Latency: n/a (wiring only).
// Backpressure: producer sees in_ready; register file stalls retirement with hold.
interface wb_demux_if
    import wb_demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
);
    localparam int NREG = 1 << AW;

    logic             in_valid;
    logic             in_ready;
    logic             in_we;
    logic [AW-1:0]    in_addr;
    logic [WIDTH-1:0] in_data;
    logic             hold;
    logic [NREG-1:0]  wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [1:0]       pending;

    // Producer / register-file side.
    modport master (
        output in_valid, in_we, in_addr, in_data, hold,
        input  in_ready, wr_en, wr_addr, wr_data, pending
    );

    // Demultiplexer side.
    modport slave (
        input  in_valid, in_we, in_addr, in_data, hold,
        output in_ready, wr_en, wr_addr, wr_data, pending
    );

endinterface

// File: rtl/wb_demux_decoder5_32.sv
// One-hot decode of a register number into per-register write enables.
// Latency: combinational.
// Backpressure: none; all-zero output whenever en is low.
module decoder5_32 #(
    parameter int AW   = 5,
    parameter int NREG = 1 << AW
) (
    input  logic            en,
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] onehot
);

    // Set exactly one bit when enabled, none otherwise.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_demux.sv
// Buffers write-back entries in a 2-deep FIFO and decodes the head into wr_en.
// Latency: entry pushed at edge N drives wr_en no earlier than cycle N+1.
// Backpressure: in_ready = (count < 2) from registered state; hold stalls retirement.
module wb_demux
    import wb_demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int ZREG  = ZREG_DEF
) (
    input  logic      clk,
    input  logic      reset,
    wb_demux_if.slave bus
);

    localparam int NREG = 1 << AW;

    entry_t     mem [2];
    logic       head;
    logic       tail;
    logic [1:0] count;

    logic       push;
    logic       retire;
    logic       write_hit;
    entry_t     head_entry;

    // in_ready depends only on stored count so it never loops through hold.
    assign bus.in_ready = (count != 2'd2);
    assign push         = bus.in_valid & bus.in_ready;
    assign retire       = (count != 2'd0) & ~bus.hold;
    assign head_entry   = mem[head];

    // Bubbles and writes to the zero register still spend their retire cycle.
    assign write_hit    = retire & head_entry.we & (head_entry.addr != AW'(ZREG));

    // Expose the head entry whenever one is stored; zero when empty.
    assign bus.wr_addr  = (count != 2'd0) ? head_entry.addr : '0;
    assign bus.wr_data  = (count != 2'd0) ? head_entry.data : '0;
    assign bus.pending  = count;

    decoder5_32 #(
        .AW   (AW),
        .NREG (NREG)
    ) u_dec (
        .en     (write_hit),
        .addr   (head_entry.addr),
        .onehot (bus.wr_en)
    );

    // FIFO pointers, occupancy and storage; reset discards everything stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[tail] <= '{we: bus.in_we, addr: bus.in_addr, data: bus.in_data};
                tail      <= ~tail;
            end
            if (retire) begin
                head <= ~head;
            end
            case ({push, retire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_demux.sv
// Directed self-checking bench for the write-back demultiplexer.
// Latency: checks one-cycle push-to-write and same-cycle push/retire ordering.
// Backpressure: exercises hold stalls, full-FIFO drop and reset flush.
module tb_wb_demux;
    import wb_demux_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    wb_demux_if #(.WIDTH(64), .AW(5)) bus ();

    wb_demux #(.WIDTH(64), .AW(5), .ZREG(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply producer inputs and let combinational outputs settle.
    task automatic drive(input logic v, input logic we, input logic [4:0] a,
                         input logic [63:0] d, input logic h);
        bus.in_valid = v;
        bus.in_we    = we;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.hold     = h;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        tick();
        tick();

        // Reset state
        check_val("rst_pending", 64'(bus.pending), 64'd0);
        check_val("rst_wr_en",   64'(bus.wr_en),   64'd0);
        check_val("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check_val("rst_wr_data", bus.wr_data,      64'd0);
        check_val("rst_ready",   64'(bus.in_ready), 64'd1);
        reset = 1'b0;
        tick();

        // Single write to r3: no combinational path, then bit 3 next cycle
        drive(1'b1, 1'b1, 5'd3, 64'hAA, 1'b0);
        check_val("w3_ready",     64'(bus.in_ready), 64'd1);
        check_val("w3_no_comb",   64'(bus.wr_en),    64'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_val("w3_wr_en",     64'(bus.wr_en),   64'h0000_0008);
        check_val("w3_wr_data",   bus.wr_data,      64'hAA);
        check_val("w3_wr_addr",   64'(bus.wr_addr), 64'd3);
        check_val("w3_pend1",     64'(bus.pending), 64'd1);
        tick();
        check_val("w3_pend0",     64'(bus.pending), 64'd0);
        check_val("w3_idle_en",   64'(bus.wr_en),   64'd0);

        // hold=1: three back-to-back pushes, third refused
        drive(1'b1, 1'b1, 5'd1, 64'h11, 1'b1);
        check_val("h_ready0",  64'(bus.in_ready), 64'd1);
        tick();
        drive(1'b1, 1'b1, 5'd2, 64'h22, 1'b1);
        check_val("h_ready1",  64'(bus.in_ready), 64'd1);
        check_val("h_en1",     64'(bus.wr_en),    64'd0);
        check_val("h_head",    64'(bus.wr_addr),  64'd1);
        tick();
        drive(1'b1, 1'b1, 5'd4, 64'h44, 1'b1);
        check_val("h_ready2",  64'(bus.in_ready), 64'd0);
        check_val("h_pend2",   64'(bus.pending),  64'd2);
        check_val("h_en2",     64'(bus.wr_en),    64'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_val("h_pend_kept", 64'(bus.pending), 64'd2);
        check_val("h_ret_a",     64'(bus.wr_en),   64'h0000_0002);
        check_val("h_ret_a_d",   bus.wr_data,      64'h11);
        tick();
        check_val("h_ret_b",     64'(bus.wr_en),   64'h0000_0004);
        check_val("h_ret_b_d",   bus.wr_data,      64'h22);
        tick();
        check_val("h_dropped_c", 64'(bus.pending), 64'd0);
        check_val("h_no_c_en",   64'(bus.wr_en),   64'd0);

        // Zero register write and bubble each take a silent retire cycle
        drive(1'b1, 1'b1, 5'd31, 64'h1F, 1'b0);
        tick();
        drive(1'b1, 1'b0, 5'd5, 64'h55, 1'b0);
        check_val("z_en_xzr",  64'(bus.wr_en),   64'd0);
        check_val("z_addr31",  64'(bus.wr_addr), 64'd31);
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_val("z_pend1",   64'(bus.pending), 64'd1);
        check_val("z_en_bub",  64'(bus.wr_en),   64'd0);
        check_val("z_addr5",   64'(bus.wr_addr), 64'd5);
        tick();
        check_val("z_pend0",   64'(bus.pending), 64'd0);

        // Push and retire in the same cycle: order r7 then r9
        drive(1'b1, 1'b1, 5'd7, 64'h77, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd9, 64'h99, 1'b0);
        check_val("pr_en7",    64'(bus.wr_en),   64'h0000_0080);
        check_val("pr_pend_a", 64'(bus.pending), 64'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_val("pr_pend_b", 64'(bus.pending), 64'd1);
        check_val("pr_en9",    64'(bus.wr_en),   64'h0000_0200);
        check_val("pr_data9",  bus.wr_data,      64'h99);
        tick();
        check_val("pr_pend0",  64'(bus.pending), 64'd0);

        // Reset with a full FIFO under hold flushes everything
        drive(1'b1, 1'b1, 5'd10, 64'hA0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 5'd12, 64'hC0, 1'b1);
        tick();
        check_val("rf_pend2",  64'(bus.pending), 64'd2);
        reset = 1'b1;
        drive(1'b1, 1'b1, 5'd13, 64'hD0, 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_val("rf_pend0",  64'(bus.pending),  64'd0);
        check_val("rf_en0",    64'(bus.wr_en),    64'd0);
        check_val("rf_ready",  64'(bus.in_ready), 64'd1);
        check_val("rf_addr0",  64'(bus.wr_addr),  64'd0);
        check_val("rf_data0",  bus.wr_data,       64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rf_quiet_en",   64'(bus.wr_en),   64'd0);
            check_val("rf_quiet_pend", 64'(bus.pending), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_demux.md
WB_DEMUX -- requirements
Module: wb_demux

Interface
REQ-001 Parameter: WIDTH, 64, data width of one register write.
REQ-002 Parameter: AW, 5, register address width; NREG = 2**AW = 32 write enables.
REQ-003 Parameter: ZREG, 31, index of the hard-wired zero register (XZR); never written.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 Port: in_valid  input  1  producer presents a write-back entry this cycle.
REQ-007 Port: in_ready  output  1  block can accept an entry this cycle.
REQ-008 Port: in_we  input  1  entry performs a register write (0 = bubble/no-write).
REQ-009 Port: in_addr  input  AW  destination register number.
REQ-010 Port: in_data  input  WIDTH  value to be written.
REQ-011 Port: hold  input  1  register file cannot take a write this cycle.
REQ-012 Port: wr_en  output  NREG  one-hot (or all-zero) per-register write enable.
REQ-013 Port: wr_addr  output  AW  address of the entry being retired.
REQ-014 Port: wr_data  output  WIDTH  data of the entry being retired.
REQ-015 Port: pending  output  2  number of buffered entries (0..2).

Function
REQ-016 The block SHALL buffer entries in a 2-entry FIFO (1-bit head/tail pointers, 2-bit count) and decode the head entry into wr_en.
REQ-017 in_ready SHALL equal (count < 2), derived from registered count only, independent of hold and of a same-cycle retire.
REQ-018 An entry SHALL be pushed iff in_valid & in_ready; in_valid while in_ready=0 SHALL be ignored, with no state change.
REQ-019 The head entry SHALL retire in any cycle with count > 0 and hold = 0; count decrements on the next edge.
REQ-020 Minimum latency: entry pushed at edge N SHALL drive wr_en at the earliest in cycle N+1 (no combinational in-to-wr path).
REQ-021 wr_en[in_addr] SHALL be 1 only in the retire cycle, only when the head has we=1 and addr != ZREG; all other bits 0.
REQ-022 An entry with we=0 or addr=ZREG SHALL still consume one retire cycle, with wr_en all-zero.
REQ-023 When count = 0 or hold = 1, wr_en SHALL be all-zero; wr_addr/wr_data SHALL show the head entry (0 when empty).
REQ-024 Simultaneous push and retire SHALL leave count unchanged and preserve FIFO order.
REQ-025 Pointers SHALL wrap 1 -> 0 without loss; entries SHALL retire strictly in push order.
REQ-026 pending SHALL equal registered count.

Reset
REQ-027 On a clk edge with reset=1: count, head and tail pointers SHALL become 0 and stored entries SHALL be discarded.
REQ-028 During and after reset: wr_en=0, wr_addr=0, wr_data=0, pending=0, in_ready=1.
REQ-029 A push presented in a reset cycle SHALL be dropped; reset mid-operation SHALL lose all buffered entries.

Structure
REQ-030 WIDTH, AW, ZREG defaults and the entry record type (we, addr, data) SHALL live in the shared processor package.
REQ-031 The AW-to-NREG one-hot decode SHALL be a sub-module named decoder5_32 with an enable input; FIFO control stays in wb_demux.

Verification
REQ-032 After reset, push {we=1, addr=3, data=0xAA}, hold=0 -> next cycle wr_en=0x0000_0008, wr_data=0xAA, then pending=0.
REQ-033 hold=1, push 3 entries back-to-back -> first two accepted, in_ready=0 on third, pending=2, wr_en=0 throughout.
REQ-034 Push {we=1, addr=31} then {we=0, addr=5} -> two retire cycles, wr_en=0 both; pending returns to 0.
REQ-035 Count=1, push and retire same cycle (addr 7 then addr 9) -> pending stays 1, wr_en bits 7 then 9 in order.
REQ-036 Count=2 with hold=1, assert reset -> next cycle pending=0, wr_en=0, in_ready=1; no write retires afterward.
